// File: rtl/wires.sv
// Shared types for the sequential multiplier.
//   mul_op_type        - one-hot request opcode {mul, mulh, mulhsu, mulhu}
//   mul_seq_state_type - multiplier FSM states
//   mul_kind_type      - opcode after priority decode, held while calculating
//   MUL_SEQ_STEPS      - number of 17x17 partial-product steps for a full product
package wires;

    typedef struct packed {
        logic mul;
        logic mulh;
        logic mulhsu;
        logic mulhu;
    } mul_op_type;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_seq_state_type;

    typedef enum logic [1:0] {
        MUL_KIND_MUL,
        MUL_KIND_MULH,
        MUL_KIND_MULHSU,
        MUL_KIND_MULHU
    } mul_kind_type;

    localparam int unsigned MUL_SEQ_STEPS = 4;

    // Priority mul > mulh > mulhsu > mulhu; anything without a higher bit
    // set (including all-zero) runs as mulhu.
    function automatic mul_kind_type mul_decode(input mul_op_type op);
        if (op.mul) begin
            return MUL_KIND_MUL;
        end else if (op.mulh) begin
            return MUL_KIND_MULH;
        end else if (op.mulhsu) begin
            return MUL_KIND_MULHSU;
        end else begin
            return MUL_KIND_MULHU;
        end
    endfunction

endpackage

// File: rtl/mul17.sv
// Combinational 17x17 signed multiplier.
//   i_a, i_b : 17-bit signed operands
//   o_p      : 34-bit signed product (exact, cannot overflow)
module mul17 (
    input  logic signed [16:0] i_a,
    input  logic signed [16:0] i_b,
    output logic signed [33:0] o_p
);

    logic signed [33:0] w_a;
    logic signed [33:0] w_b;

    assign w_a = {{17{i_a[16]}}, i_a};
    assign w_b = {{17{i_b[16]}}, i_b};
    assign o_p = w_a * w_b;

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier built from one 17x17 signed multiplier.
// Each 33-bit extended operand is split into a non-negative low half and a
// signed high half; four partial products are accumulated, one per cycle.
// mul needs only the low word, so the hi*hi step is skipped for it.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : request accepted this cycle when req_valid=1
//   req_op       : one-hot opcode {mul, mulh, mulhsu, mulhu}
//   req_rdata1/2 : multiplicand / multiplier
//   flush        : abort any in-flight operation
//   resp_valid   : result available (registered, only in DONE)
//   resp_ready   : consumer takes the result
//   resp_result  : result word
module mul_seq
    import wires::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mul_op_type  req_op,
    input  logic [31:0] req_rdata1,
    input  logic [31:0] req_rdata2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result
);

    mul_seq_state_type  r_state;
    logic [1:0]         r_step;
    logic signed [65:0] r_acc;
    logic [32:0]        r_op1;
    logic [32:0]        r_op2;
    mul_kind_type       r_kind;
    logic               r_resp_valid;
    logic [31:0]        r_resp_result;

    mul_kind_type       w_kind;
    logic               w_sx1;
    logic               w_sx2;
    logic [32:0]        w_ext1;
    logic [32:0]        w_ext2;
    logic               w_accept;

    logic signed [16:0] w_lo1;
    logic signed [16:0] w_hi1;
    logic signed [16:0] w_lo2;
    logic signed [16:0] w_hi2;
    logic signed [16:0] w_a;
    logic signed [16:0] w_b;
    logic signed [33:0] w_prod;
    logic signed [65:0] w_prod_ext;
    logic signed [65:0] w_term;
    logic signed [65:0] w_acc_next;
    logic               w_last;

    // ---------------------------------------------------------------
    // Request decode and operand extension
    // ---------------------------------------------------------------
    assign w_kind = mul_decode(req_op);
    assign w_sx1  = (w_kind != MUL_KIND_MULHU);
    assign w_sx2  = (w_kind == MUL_KIND_MUL) || (w_kind == MUL_KIND_MULH);
    assign w_ext1 = {w_sx1 & req_rdata1[31], req_rdata1};
    assign w_ext2 = {w_sx2 & req_rdata2[31], req_rdata2};

    assign req_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && resp_ready));
    assign w_accept  = req_valid && req_ready;

    // ---------------------------------------------------------------
    // Partial-product datapath
    // ---------------------------------------------------------------
    // Low halves carry a zero top bit so the signed multiplier treats them
    // as unsigned 16-bit values.
    assign w_lo1 = {1'b0, r_op1[15:0]};
    assign w_hi1 = r_op1[32:16];
    assign w_lo2 = {1'b0, r_op2[15:0]};
    assign w_hi2 = r_op2[32:16];

    always_comb begin
        w_a = w_lo1;
        w_b = w_lo2;
        unique case (r_step)
            2'd0: begin w_a = w_lo1; w_b = w_lo2; end
            2'd1: begin w_a = w_hi1; w_b = w_lo2; end
            2'd2: begin w_a = w_lo1; w_b = w_hi2; end
            2'd3: begin w_a = w_hi1; w_b = w_hi2; end
            default: begin w_a = w_lo1; w_b = w_lo2; end
        endcase
    end

    mul17 u_mul17 (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_prod)
    );

    assign w_prod_ext = {{32{w_prod[33]}}, w_prod};

    always_comb begin
        w_term = w_prod_ext;
        unique case (r_step)
            2'd0:    w_term = w_prod_ext;
            2'd1:    w_term = w_prod_ext <<< 16;
            2'd2:    w_term = w_prod_ext <<< 16;
            2'd3:    w_term = w_prod_ext <<< 32;
            default: w_term = w_prod_ext;
        endcase
    end

    // Step 0 starts a fresh sum, so a stale accumulator never leaks in.
    assign w_acc_next = (r_step == 2'd0) ? w_term : (r_acc + w_term);

    // hi*hi only lands at bit 32 and up, which mul never returns.
    assign w_last = (r_step == 2'(MUL_SEQ_STEPS - 1)) ||
                    ((r_kind == MUL_KIND_MUL) && (r_step == 2'(MUL_SEQ_STEPS - 2)));

    // ---------------------------------------------------------------
    // Control FSM with registered response
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_step        <= 2'd0;
            r_acc         <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_kind        <= MUL_KIND_MUL;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
        end else if (flush) begin
            r_state      <= IDLE;
            r_step       <= 2'd0;
            r_resp_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_state       <= DONE;
                        r_step        <= 2'd0;
                        r_resp_valid  <= 1'b1;
                        r_resp_result <= (r_kind == MUL_KIND_MUL) ? w_acc_next[31:0]
                                                                  : w_acc_next[63:32];
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // An accept overrides the DONE->IDLE move above, giving back-to-back
            // operation when the consumer and a new request meet in one cycle.
            if (w_accept) begin
                r_op1   <= w_ext1;
                r_op2   <= w_ext2;
                r_kind  <= w_kind;
                r_step  <= 2'd0;
                r_state <= CALC;
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_mul_seq;
    import wires::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    mul_op_type  req_op;
    logic [31:0] req_rdata1;
    logic [31:0] req_rdata2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    mul_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rdata1  (req_rdata1),
        .req_rdata2  (req_rdata2),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full product with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        if (op[3]) begin
            p = sa * sb;
            return p[31:0];
        end
        if (op[2])      p = sa * sb;
        else if (op[1]) p = sa * ub;
        else            p = ua * ub;
        return p[63:32];
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return op[3] ? 3 : 4;
    endfunction

    // Transaction model: busy with a countdown, or holding a result.
    bit          m_pending;
    bit          m_valid;
    int          m_wait;
    logic [31:0] m_result;

    function automatic bit exp_ready();
        return !flush && ((!m_pending && !m_valid) || (m_valid && resp_ready));
    endfunction

    always @(posedge clk or negedge rst) begin
        bit          pend, val, acc;
        int          wt;
        logic [31:0] res;
        if (!rst) begin
            m_pending <= 1'b0;
            m_valid   <= 1'b0;
            m_wait    <= 0;
            m_result  <= '0;
        end else begin
            acc  = req_valid && exp_ready();
            pend = m_pending;
            val  = m_valid;
            wt   = m_wait;
            res  = m_result;
            if (flush) begin
                pend = 1'b0;
                val  = 1'b0;
            end else begin
                if (val && resp_ready) val = 1'b0;
                if (pend) begin
                    wt--;
                    if (wt == 0) begin
                        pend = 1'b0;
                        val  = 1'b1;
                    end
                end
                if (acc) begin
                    pend = 1'b1;
                    wt   = ref_lat(req_op);
                    res  = ref_mul(req_op, req_rdata1, req_rdata2);
                end
            end
            m_pending <= pend;
            m_valid   <= val;
            m_wait    <= wt;
            m_result  <= res;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready()});
            if (m_valid) chk("resp_result", resp_result, m_result);
        end
    end

    // Present a request for one cycle; returns 1ns after the accept edge with
    // junk on the request inputs so the latched operands must govern.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_op     = mul_op_type'(op);
        req_rdata1 = a;
        req_rdata2 = b;
        resp_ready = 1'b0;
        flush      = 1'b0;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op     = mul_op_type'(4'($urandom));
        req_rdata1 = $urandom;
        req_rdata2 = $urandom;
    endtask

    task automatic consume();
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(op, a, b);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        chk({name, "_early_valid"}, {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_result"}, resp_result, exp);
        consume();
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_op     = mul_op_type'(4'b0000);
        req_rdata1 = '0;
        req_rdata2 = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_resp_result", resp_result, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;

        run_op("mul_neg", 4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 3);
        run_op("mulh_min", 4'b0100, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
        run_op("mulhu_max", 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
        run_op("mulhsu_m1", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        run_op("op_zero", 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
        run_op("multi_hot", 4'b0110, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);

        // Consumer stalls in DONE, then takes the result while a new request lands.
        issue(4'b1000, 32'h0001_0001, 32'h0001_0001);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_result", resp_result, 32'h0002_0001);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = mul_op_type'(4'b0001);
        req_rdata1 = 32'hFFFF_FFFF;
        req_rdata2 = 32'h0000_0002;
        @(negedge clk);
        chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b_early_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_result", resp_result, 32'h0000_0001);
        consume();

        // Flush during step 2, with a request offered in the flush cycle.
        issue(4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        @(posedge clk); #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("flush_no_valid", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        run_op("post_flush_mulh", 4'b0100, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);

        // Reset between edges while calculating.
        issue(4'b1000, 32'h0000_1234, 32'h0000_5678);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("async_rst_result", resp_result, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'd0, resp_valid}, 32'd0);
        end
        run_op("post_rst_mul", 4'b1000, 32'd7, 32'd6, 32'h0000_002A, 3);

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) req_op = mul_op_type'(4'(1 << $urandom_range(0, 3)));
            else                          req_op = mul_op_type'(4'($urandom));
            req_rdata1 = pick_operand();
            req_rdata2 = pick_operand();
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL use one clock, clk; reset is asynchronous and active-low, port rst (rst=0 resets).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  async active-low reset.
REQ-004 SHALL have ports: req_valid  in  1  request present.
REQ-005 SHALL have ports: req_ready  out  1  request accepted this cycle when req_valid=1.
REQ-006 SHALL have ports: req_op  in  mul_op_type  one-hot {mul, mulh, mulhsu, mulhu}.
REQ-007 SHALL have ports: req_rdata1 / req_rdata2  in  32 each  multiplicand / multiplier.
REQ-008 SHALL have ports: flush  in  1  kill in-flight operation.
REQ-009 SHALL have ports: resp_valid  out  1  result available.
REQ-010 SHALL have ports: resp_ready  in  1  consumer takes result.
REQ-011 SHALL have ports: resp_result  out  32  result word.
REQ-012 SHALL have parameter: none; widths are fixed at 32-bit operands and 17x17 partial products.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, CALC and DONE, plus a 2-bit step counter and a 66-bit signed accumulator.
REQ-014 SHALL decode the operation on acceptance with priority mul>mulh>mulhsu>mulhu; an all-zero req_op is executed as mulhu.
REQ-015 SHALL extend operands to 33 bits: op1 is sign-extended for mul/mulh/mulhsu, else zero-extended; op2 is sign-extended for mul/mulh, else zero-extended.
REQ-016 SHALL split each 33-bit operand into lo={0,bits[15:0]} (17 bits, non-negative) and hi=bits[32:16] (17 bits, signed).
REQ-017 SHALL drive req_ready=1 in IDLE, and in DONE when resp_ready=1; req_ready SHALL be 0 otherwise and whenever flush=1.
REQ-018 SHALL latch the operands and decoded op on accept (req_valid&req_ready), then enter CALC with step=0.
REQ-019 SHALL perform one CALC step per cycle, in this order: step0 acc=lo1*lo2; step1 acc+=(hi1*lo2)<<16; step2 acc+=(lo1*hi2)<<16; step3 acc+=(hi1*hi2)<<32.
REQ-020 SHALL skip step3 for mul, because it cannot affect bits[31:0]: mul goes CALC->DONE after step2, and the other ops after step3.
REQ-021 SHALL raise resp_valid exactly 3 cycles (mul) or 4 cycles (mulh/mulhsu/mulhu) after the accept edge.
REQ-022 SHALL drive resp_result=acc[31:0] for mul and acc[63:32] otherwise, registered and valid only in DONE.
REQ-023 SHALL hold resp_valid and resp_result stable in DONE until resp_ready=1.
REQ-024 SHALL move DONE->IDLE on resp_ready=1 with req_valid=0, and DONE->CALC (new operands) on resp_ready=1 with req_valid=1 in the same cycle.
REQ-025 SHALL force the next state to IDLE on flush=1 in any state: resp_valid=0 next cycle, no request accepted that cycle, accumulator contents don't-care.
REQ-026 SHALL ignore req_valid and input changes while in CALC; the latched operands SHALL govern the result.

Reset
REQ-027 SHALL on rst=0, immediately and regardless of clk, set state=IDLE, step=0, acc=0, resp_valid=0, resp_result=0 and req_ready=1 (once rst=1).
REQ-028 SHALL abort any operation interrupted by reset mid-CALC or in DONE without producing a response; the first request after reset SHALL complete normally.

Structure
REQ-029 SHALL reuse mul_op_type from package wires and add there an enum mul_seq_state_type {IDLE, CALC, DONE} and a step-count constant MUL_SEQ_STEPS=4.
REQ-030 SHALL instantiate one combinational sub-module mul17 (17x17 signed -> 34-bit signed product); operand muxing, shifting and accumulation SHALL remain in mul_seq.

Verification
REQ-031 SHALL check: mul 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFE, resp_valid 3 cycles after accept.
REQ-032 SHALL check: mulh 0x80000000*0x80000000 -> 0x40000000, and mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, each with 4-cycle latency.
REQ-033 SHALL check: mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; all-zero req_op with 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE (mulhu).
REQ-034 SHALL check: resp_ready held 0 for 5 cycles in DONE -> resp_result stable, req_ready=0; then resp_ready=1 with a new req_valid -> accepted the same cycle, next result correct.
REQ-035 SHALL check: flush at step2 -> state IDLE next cycle, no resp_valid; a following mulh 0x00000003*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 SHALL check: rst asserted mid-CALC between clock edges -> outputs at reset values at once; after release, mul 7*6 -> 0x0000002A in 3 cycles.
